mux_8x1_scan_n: RTL and testbench
=================================

// Module: mux_8x1_scan_n
// PURPOSE
//  Sequential 8-to-1 collector, the gathering counterpart of the 1-to-8 channel demux.
//  On start, it snapshots eight BITS-wide channel inputs and an enable mask.
//  It then emits each enabled channel, lowest index first, on a single output bus with a valid/ready handshake.
//  A one-cycle done pulse follows the last transfer. It sits between the per-channel datapath and a shared consumer.
// PARAMETERS
//  BITS  3  width of each channel and of OUT
// PORTS
//  clock   in   1     system clock, rising edge
//  reset   in   1     asynchronous, active-low reset
//  start   in   1     begin a scan; sampled only in IDLE
//  mask    in   8     channel enable, bit i enables Di; captured with data on start
//  D7..D0  in   BITS  channel data inputs; captured on start
//  ready   in   1     consumer accepts OUT/SEL this cycle
//  OUT     out  BITS  data of the channel being presented
//  SEL     out  3     index of the channel being presented
//  valid   out  1     OUT/SEL hold a transfer
//  busy    out  1     scan in progress (SEND state)
//  done    out  1     one-cycle pulse after the final transfer
// BEHAVIOUR
//  - Clock and reset: single clock domain. reset=0 forces all state asynchronously.
//    It sets state IDLE, snapshot registers 0, idx 0, and OUT=0, SEL=0, valid=0, busy=0, done=0.
//  - States: IDLE, SEND, DONE (2-bit encoded, registered).
//  - IDLE, start=0: stay in IDLE.
//  - IDLE, start=1: at that edge, capture D0..D7 and mask into snapshot registers.
//    If the captured mask is nonzero, go to SEND with idx = lowest set mask bit.
//    If the mask is 0, go to DONE.
//  - SEND: valid=1, busy=1, OUT=snap[idx], SEL=idx.
//    - While ready=0: hold OUT and SEL stable.
//    - At an edge with ready=1, the transfer completes:
//      - If a set mask bit exists above idx, idx <= lowest such bit and stay in SEND (back-to-back transfers allowed).
//      - Otherwise, go to DONE.
//  - DONE: done=1 for exactly one cycle, valid=0, busy=0; next state IDLE.
//  - Next-enabled search: combinational priority encode over snapshot mask bits strictly above idx.
//    idx never wraps; after bit 7 the scan ends.
//  - Latency: start sampled at edge k gives the first valid in the cycle after edge k.
//    Each transfer takes 1 cycle at ready=1.
//    Total = popcount(mask) transfer cycles + 1 DONE cycle.
//  - When valid=0: OUT=0 and SEL=0.
//  - Ignored inputs:
//    - ready while valid=0 has no effect.
//    - start outside IDLE is ignored, including in DONE.
//    - Changes to D*/mask after capture do not affect the current scan.
//  - Reset mid-scan: the scan is aborted immediately. No done pulse is produced and pending transfers are lost.
// TESTING
//  1 mask=8'hFF, Di=i, ready=1, pulse start -> valid 8 consecutive cycles with SEL/OUT 0..7, then done=1 for 1 cycle, then IDLE.
//  2 mask=8'hA4, Di=7-i, ready=1 -> transfers SEL=2/OUT=5, SEL=5/OUT=2, SEL=7/OUT=0, then done.
//  3 mask=8'h03, ready=0 for 3 cycles after start -> SEL=0/OUT held stable 4 cycles total; ready=1 -> SEL=1, then done.
//  4 mask=8'h00, start -> done=1 in the next cycle, valid and busy never assert.
//  5 mask=8'h81, during SEND pulse start and change D0..D7 -> no restart, OUT shows captured values, SEL 0 then 7.
//  6 reset=0 while SEND at SEL=3 -> valid/busy/OUT/SEL go 0 immediately, no done; after release, a new start works normally.

Source files
------------

// File: rtl/mux_8x1_scan_n_if.sv
// Bus bundle for the 8-to-1 sequential collector: start/mask/channel data in,
// one valid/ready transfer lane plus status out.
interface mux_8x1_scan_n_if #(
    parameter int BITS = 3
);
    logic            start;
    logic [7:0]      mask;
    logic [BITS-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic            ready;
    logic [BITS-1:0] OUT;
    logic [2:0]      SEL;
    logic            valid;
    logic            busy;
    logic            done;

    // Producer/consumer side: drives the channels and the handshake ready.
    modport master (
        output start, mask, D0, D1, D2, D3, D4, D5, D6, D7, ready,
        input  OUT, SEL, valid, busy, done
    );

    // Collector side.
    modport slave (
        input  start, mask, D0, D1, D2, D3, D4, D5, D6, D7, ready,
        output OUT, SEL, valid, busy, done
    );
endinterface

// File: rtl/mux_8x1_scan_n.sv
// Sequential 8-to-1 collector. On start, snapshots all eight channels and the
// enable mask, then presents each enabled channel (lowest index first) on a
// single valid/ready output, followed by a one-cycle done pulse.
module mux_8x1_scan_n #(
    parameter int BITS = 3
) (
    input logic              clock,
    input logic              reset,
    mux_8x1_scan_n_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0][BITS-1:0]   snap_q, snap_d;
    logic [7:0]             mask_q, mask_d;
    logic [2:0]             idx_q, idx_d;

    logic [7:0][BITS-1:0]   din;
    logic [2:0]             first_idx;
    logic [2:0]             next_idx;
    logic                   next_found;

    assign din = {bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

    // Lowest set bit of the incoming mask (only used when it is being captured).
    always_comb begin
        first_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i]) first_idx = 3'(i);
        end
    end

    // Lowest captured mask bit strictly above the current index; no wrap past 7.
    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > idx_q)) begin
                next_idx   = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    // Next-state: capture on start in IDLE, advance on each accepted transfer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = din;
                    mask_d  = bus.mask;
                    idx_d   = first_idx;
                    state_d = (bus.mask != 8'h00) ? SEND : DONE;
                end
            end
            SEND: begin
                if (bus.ready) begin
                    if (next_found) begin
                        idx_d = next_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state, so an async reset
    // clears them in the same instant.
    always_comb begin
        bus.OUT   = '0;
        bus.SEL   = '0;
        bus.valid = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            SEND: begin
                bus.valid = 1'b1;
                bus.busy  = 1'b1;
                bus.OUT   = snap_q[idx_q];
                bus.SEL   = idx_q;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // State and snapshot registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_mux_8x1_scan_n.sv
// Bench for mux_8x1_scan_n: a queue-based model of the scan plus directed
// scenarios with literal per-cycle expectations.
module tb_mux_8x1_scan_n;
    localparam int BITS = 3;

    logic clock;
    logic reset;
    logic [BITS-1:0] dv [8];

    int n_cmp = 0;
    int n_bad = 0;

    mux_8x1_scan_n_if #(.BITS(BITS)) bus ();

    assign bus.D0 = dv[0];
    assign bus.D1 = dv[1];
    assign bus.D2 = dv[2];
    assign bus.D3 = dv[3];
    assign bus.D4 = dv[4];
    assign bus.D5 = dv[5];
    assign bus.D6 = dv[6];
    assign bus.D7 = dv[7];

    mux_8x1_scan_n #(.BITS(BITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: pending transfers as a queue of {sel,out}, then one done cycle.
    logic [5:0] q [$];
    bit         done_pend = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            done_pend = 0;
        end else if (q.size() > 0) begin
            if (bus.ready) begin
                void'(q.pop_front());
                if (q.size() == 0) done_pend = 1;
            end
        end else if (done_pend) begin
            done_pend = 0;
        end else if (bus.start) begin
            for (int i = 0; i < 8; i++)
                if (bus.mask[i]) q.push_back({3'(i), dv[i]});
            if (q.size() == 0) done_pend = 1;
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clock) begin
        logic [BITS-1:0] e_out;
        logic [2:0]      e_sel;
        logic            e_v, e_d;
        e_out = '0; e_sel = '0; e_v = 0; e_d = 0;
        if (q.size() > 0) begin
            e_v = 1; e_sel = q[0][5:3]; e_out = q[0][2:0];
        end else if (done_pend) begin
            e_d = 1;
        end
        n_cmp++;
        if (bus.valid !== e_v || bus.busy !== e_v || bus.done !== e_d ||
            bus.SEL !== e_sel || bus.OUT !== e_out) begin
            n_bad++;
            $display("FAIL model t=%0t got v=%b b=%b d=%b sel=%0d out=%0d want v=%b b=%b d=%b sel=%0d out=%0d",
                     $time, bus.valid, bus.busy, bus.done, bus.SEL, bus.OUT,
                     e_v, e_v, e_d, e_sel, e_out);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Literal check of the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic v, input logic [2:0] s,
                       input logic [BITS-1:0] o, input logic d);
        @(negedge clock);
        n_cmp++;
        if (bus.valid !== v || bus.busy !== v || bus.SEL !== s ||
            bus.OUT !== o || bus.done !== d) begin
            n_bad++;
            $display("FAIL %s t=%0t got v=%b b=%b sel=%0d out=%0d d=%b want v=%b sel=%0d out=%0d d=%b",
                     nm, $time, bus.valid, bus.busy, bus.SEL, bus.OUT, bus.done, v, s, o, d);
        end
        tick();
    endtask

    task automatic go(input logic [7:0] m);
        bus.mask  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.mask  = '0;
        bus.ready = 1'b0;
        for (int i = 0; i < 8; i++) dv[i] = '0;

        // Reset state
        cyc("reset", 0, 0, 0, 0);
        cyc("reset2", 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        cyc("idle", 0, 0, 0, 0);

        // 1: all channels, Di = i
        for (int i = 0; i < 8; i++) dv[i] = 3'(i);
        bus.ready = 1'b1;
        go(8'hFF);
        for (int k = 0; k < 8; k++) cyc("t1_xfer", 1, 3'(k), 3'(k), 0);
        cyc("t1_done", 0, 0, 0, 1);
        cyc("t1_idle", 0, 0, 0, 0);

        // 2: sparse mask A4, Di = 7-i
        for (int i = 0; i < 8; i++) dv[i] = 3'(7 - i);
        go(8'hA4);
        cyc("t2_sel2", 1, 2, 5, 0);
        cyc("t2_sel5", 1, 5, 2, 0);
        cyc("t2_sel7", 1, 7, 0, 0);
        cyc("t2_done", 0, 0, 0, 1);
        cyc("t2_idle", 0, 0, 0, 0);

        // 3: backpressure holds the presented channel
        for (int i = 0; i < 8; i++) dv[i] = 3'(i + 1);
        bus.ready = 1'b0;
        go(8'h03);
        cyc("t3_hold", 1, 0, 1, 0);
        cyc("t3_hold", 1, 0, 1, 0);
        cyc("t3_hold", 1, 0, 1, 0);
        bus.ready = 1'b1;
        cyc("t3_acc0", 1, 0, 1, 0);
        cyc("t3_sel1", 1, 1, 2, 0);
        cyc("t3_done", 0, 0, 0, 1);
        cyc("t3_idle", 0, 0, 0, 0);

        // 4: empty mask goes straight to done
        go(8'h00);
        cyc("t4_done", 0, 0, 0, 1);
        cyc("t4_idle", 0, 0, 0, 0);

        // 5: start and data changes during SEND/DONE are ignored
        for (int i = 0; i < 8; i++) dv[i] = 3'(i ^ 5);
        go(8'h81);
        bus.start = 1'b1;
        bus.mask  = 8'hFF;
        for (int i = 0; i < 8; i++) dv[i] = 3'd3;
        cyc("t5_sel0", 1, 0, 5, 0);
        cyc("t5_sel7", 1, 7, 2, 0);
        cyc("t5_done", 0, 0, 0, 1);
        bus.start = 1'b0;
        cyc("t5_idle", 0, 0, 0, 0);

        // 6: reset mid-scan aborts without done
        for (int i = 0; i < 8; i++) dv[i] = 3'(i);
        go(8'hFF);
        cyc("t6_sel0", 1, 0, 0, 0);
        cyc("t6_sel1", 1, 1, 1, 0);
        cyc("t6_sel2", 1, 2, 2, 0);
        @(negedge clock);
        n_cmp++;
        if (bus.SEL !== 3'd3 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL t6_sel3 got sel=%0d v=%b want sel=3 v=1", bus.SEL, bus.valid);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.OUT !== '0 ||
            bus.SEL !== '0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_abort got v=%b b=%b out=%0d sel=%0d d=%b want all 0",
                     bus.valid, bus.busy, bus.OUT, bus.SEL, bus.done);
        end
        tick();
        reset = 1'b1;
        cyc("t6_nodone", 0, 0, 0, 0);
        cyc("t6_nodone2", 0, 0, 0, 0);
        dv[4] = 3'd6;
        go(8'h10);
        cyc("t6_restart", 1, 4, 6, 0);
        cyc("t6_done", 0, 0, 0, 1);
        cyc("t6_idle", 0, 0, 0, 0);

        // Random scans with random backpressure, checked by the model only.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) dv[i] = 3'($urandom_range(0, 7));
            bus.ready = 1'($urandom_range(0, 1));
            go(8'($urandom_range(0, 255)));
            for (int c = 0; c < 30; c++) begin
                bus.ready = 1'($urandom_range(0, 1));
                bus.start = 1'($urandom_range(0, 1));
                for (int i = 0; i < 8; i++) dv[i] = 3'($urandom_range(0, 7));
                tick();
            end
            bus.start = 1'b0;
            bus.ready = 1'b1;
            for (int c = 0; c < 12; c++) tick();
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
